// File: rtl/thermo_pkg.sv
// Shared types and encodings for the thermostat sequencing controller.
package thermo_pkg;

  localparam int unsigned TEMP_W = 4;
  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_HEAT = 2'd1;
  localparam logic [STATE_W-1:0] ST_COOL = 2'd2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = ST_IDLE,
    HEAT = ST_HEAT,
    COOL = ST_COOL
  } state_t;

  typedef enum logic [1:0] {
    C_NONE = 2'd0,
    C_LT   = 2'd1,
    C_EQ   = 2'd2,
    C_GT   = 2'd3
  } class_t;

  // {lt, eq, gt} one-hot view of a classification; C_NONE maps to all zero.
  function automatic logic [2:0] class_onehot(input class_t c);
    logic [2:0] v;
    v = 3'b000;
    case (c)
      C_LT:    v = 3'b100;
      C_EQ:    v = 3'b010;
      C_GT:    v = 3'b001;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/temp_classifier.sv
// Combinational unsigned compare of a temperature code against a fixed setpoint.
module temp_classifier
  import thermo_pkg::*;
#(
  parameter int unsigned SETPOINT = 12
) (
  input  logic [TEMP_W-1:0] i_temp,
  output class_t            o_class_c
);

  localparam logic [TEMP_W-1:0] SP = TEMP_W'(SETPOINT);

  always_comb begin
    o_class_c = C_EQ;
    if (i_temp < SP) begin
      o_class_c = C_LT;
    end else if (i_temp > SP) begin
      o_class_c = C_GT;
    end
  end

endmodule

// File: rtl/thermostat_ctrl.sv
// Debounced IDLE/HEAT/COOL controller with minimum-run protection against short-cycling.
module thermostat_ctrl
  import thermo_pkg::*;
#(
  parameter int unsigned SETPOINT = 12,
  parameter int unsigned CONFIRM  = 3,
  parameter int unsigned MIN_RUN  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample,
  input  logic [TEMP_W-1:0]  temp,
  output logic               heat,
  output logic               cool,
  output logic               lt,
  output logic               eq,
  output logic               gt,
  output logic [STATE_W-1:0] state
);

  localparam int unsigned CONF_W = $clog2(CONFIRM + 1);
  localparam int unsigned RUN_W  = $clog2(MIN_RUN + 1);
  localparam logic [CONF_W-1:0] CONF_MAX = CONF_W'(CONFIRM);
  localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(MIN_RUN);

  state_t            r_state;
  state_t            w_next_state;
  class_t            w_class;
  class_t            r_prev;
  logic [CONF_W-1:0] r_conf;
  logic [CONF_W-1:0] w_conf_upd;
  logic [RUN_W-1:0]  r_run;
  logic [RUN_W-1:0]  w_run_upd;
  logic              w_conf_done;
  logic              w_run_done;
  logic              r_heat;
  logic              r_cool;
  logic              r_lt;
  logic              r_eq;
  logic              r_gt;

  temp_classifier #(
    .SETPOINT (SETPOINT)
  ) u_classifier (
    .i_temp    (temp),
    .o_class_c (w_class)
  );

  // Post-update counter values for this sample; decisions are taken on these.
  always_comb begin
    w_conf_upd = CONF_W'(1);
    w_run_upd  = '0;
    if (w_class == r_prev) begin
      w_conf_upd = (r_conf == CONF_MAX) ? r_conf : r_conf + CONF_W'(1);
    end
    if (r_state == HEAT || r_state == COOL) begin
      w_run_upd = (r_run == RUN_MAX) ? r_run : r_run + RUN_W'(1);
    end
    w_conf_done = (w_conf_upd == CONF_MAX);
    w_run_done  = (w_run_upd == RUN_MAX);
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (sample && w_conf_done) begin
          if (w_class == C_LT) w_next_state = HEAT;
          else if (w_class == C_GT) w_next_state = COOL;
        end
      end
      HEAT: begin
        if (sample && w_conf_done && w_run_done && (w_class == C_EQ || w_class == C_GT))
          w_next_state = IDLE;
      end
      COOL: begin
        if (sample && w_conf_done && w_run_done && (w_class == C_EQ || w_class == C_LT))
          w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_heat  <= 1'b0;
      r_cool  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_heat  <= (w_next_state == HEAT);
      r_cool  <= (w_next_state == COOL);
    end
  end

  // Counters restart on any state change so each state needs its own confirmation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= C_NONE;
      r_conf <= '0;
      r_run  <= '0;
      r_lt   <= 1'b0;
      r_eq   <= 1'b0;
      r_gt   <= 1'b0;
    end else if (sample) begin
      r_prev <= w_class;
      {r_lt, r_eq, r_gt} <= class_onehot(w_class);
      if (w_next_state != r_state) begin
        r_conf <= '0;
        r_run  <= '0;
      end else begin
        r_conf <= w_conf_upd;
        r_run  <= w_run_upd;
      end
    end
  end

  assign heat  = r_heat;
  assign cool  = r_cool;
  assign lt    = r_lt;
  assign eq    = r_eq;
  assign gt    = r_gt;
  assign state = r_state;

endmodule

// File: tb/tb_thermostat_ctrl.sv
// Directed bench for thermostat_ctrl with hand-computed expectations.
module tb_thermostat_ctrl;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst_n;
  logic       sample;
  logic [3:0] temp;

  logic       heat, cool, lt, eq, gt;
  logic [1:0] state;
  logic       heat0, cool0, lt0, eq0, gt0;
  logic [1:0] state0;

  int errors = 0;
  int checks = 0;

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  thermostat_ctrl #(.SETPOINT(12), .CONFIRM(3), .MIN_RUN(8)) dut (
    .clk(clk), .rst_n(rst_n), .sample(sample), .temp(temp),
    .heat(heat), .cool(cool), .lt(lt), .eq(eq), .gt(gt), .state(state)
  );

  thermostat_ctrl #(.SETPOINT(0), .CONFIRM(3), .MIN_RUN(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .sample(sample), .temp(temp),
    .heat(heat0), .cool(cool0), .lt(lt0), .eq(eq0), .gt(gt0), .state(state0)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then look at outputs just after the edge.
  task automatic step(input logic s, input logic [3:0] t);
    sample = s;
    temp   = t;
    @(posedge clk);
    #1;
    chk("excl", 8'(heat & cool), 8'd0);
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic h, input logic c,
                         input logic l, input logic e, input logic g);
    chk({tag, "_state"}, 8'(state), 8'(st));
    chk({tag, "_heat"}, 8'(heat), 8'(h));
    chk({tag, "_cool"}, 8'(cool), 8'(c));
    chk({tag, "_lteqgt"}, 8'({lt, eq, gt}), 8'({l, e, g}));
  endtask

  initial begin
    rst_n  = 1'b0;
    sample = 1'b0;
    temp   = 4'd0;

    // 1. Reset with no clock running
    #3;
    chk_all("rst", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst0_state", 8'(state0), 8'd0);
    clk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b0, 4'($urandom_range(15)));
    chk_all("idle10", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 2. Unconfirmed then confirmed LT
    step(1'b1, 4'd5);
    chk_all("lt1", 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'd5);
    step(1'b1, 4'd12);
    chk_all("eqbrk", 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 4'd5);
    step(1'b1, 4'd5);
    chk_all("lt2", 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'd5);
    chk_all("heat_on", 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // 3. Minimum run, then reversal through IDLE
    for (int i = 1; i < 8; i++) begin
      step(1'b1, 4'd13);
      chk("minrun_heat", 8'(heat), 8'd1);
      chk("minrun_state", 8'(state), 8'd1);
    end
    step(1'b1, 4'd13);
    chk_all("heat_off", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'd13);
    step(1'b1, 4'd13);
    chk_all("pre_cool", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'd13);
    chk_all("cool_on", 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    // 4. Strobe gating
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 4'(i));
      chk("gate_state", 8'(state), 8'd2);
    end
    chk_all("gate", 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    // 5. Async reset mid-COOL, between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("arst", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    step(1'b1, 4'd2);
    step(1'b1, 4'd2);
    chk_all("post_rst2", 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'd2);
    chk_all("post_rst3", 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // 6. Chatter around the setpoint
    step(1'b0, 4'd0);
    #2;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      logic [3:0] t;
      t = (i % 2 == 0) ? 4'd11 : 4'd13;
      step(1'b1, t);
      chk("chat_state", 8'(state), 8'd0);
      chk("chat_lt", 8'(lt), 8'(t == 4'd11));
      chk("chat_gt", 8'(gt), 8'(t == 4'd13));
    end

    // SETPOINT=0 instance: temp 0 is always equal
    step(1'b0, 4'd0);
    #2;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'd0);
      chk("sp0_state", 8'(state0), 8'd0);
      chk("sp0_heat", 8'(heat0), 8'd0);
      chk("sp0_cool", 8'(cool0), 8'd0);
      chk("sp0_lteqgt", 8'({lt0, eq0, gt0}), 8'b010);
    end
    step(1'b0, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/thermostat_ctrl.md
# thermostat_ctrl

Sequencing controller for the 4-bit temperature comparison path. On each sample strobe it classifies the incoming temperature against a setpoint (less / equal / greater), debounces the classification over consecutive samples, and drives mutually exclusive heat and cool outputs through an IDLE/HEAT/COOL state machine. A minimum-run interval prevents short-cycling. It sits between the temperature source and the actuator outputs.

## Interface
- SETPOINT, 12, 4-bit threshold; temp == SETPOINT is "equal"
- CONFIRM, 3, consecutive identical classifications required before acting (>= 1)
- MIN_RUN, 8, minimum sample count spent in HEAT or COOL before leaving (>= 1)

- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- sample  input  1  one-cycle strobe; temp is only examined when high
- temp  input  4  unsigned temperature code
- heat  output  1  heater enable, high only in HEAT
- cool  output  1  cooler enable, high only in COOL
- lt / eq / gt  output  1 each  registered classification of the last accepted sample; one-hot after the first sample
- state  output  2  current FSM state (IDLE=0, HEAT=1, COOL=2)

## Operation
- Cycles with sample=0: no register changes; temp ignored.
- Classification (unsigned): LT if temp < SETPOINT, EQ if equal, GT if greater. SETPOINT=0 never yields LT; SETPOINT=15 never yields GT.
- conf_cnt: if class equals the previous accepted class, increment, saturating at CONFIRM; otherwise load 1. Width is clog2(CONFIRM+1).
- run_cnt: increments on each sample while in HEAT or COOL, saturating at MIN_RUN; held at 0 in IDLE.
- Decisions use post-update counter values from the same sample.
- IDLE -> HEAT: LT with conf_cnt == CONFIRM.
- IDLE -> COOL: GT with conf_cnt == CONFIRM.
- IDLE with EQ confirmed: stay in IDLE.
- HEAT -> IDLE: class EQ or GT, conf_cnt == CONFIRM, run_cnt == MIN_RUN.
- COOL -> IDLE: class EQ or LT, conf_cnt == CONFIRM, run_cnt == MIN_RUN.
- There are no direct HEAT <-> COOL transitions. A reversal always passes through IDLE and needs a fresh confirmation.
- On every state transition: conf_cnt and run_cnt clear to 0. The previous-class register keeps the current class.
- heat and cool are Moore outputs decoded from registered state. They are never high together. Illegal state encoding recovers to IDLE.

## Timing
- Reset (asynchronous, immediate, no clock needed) sets:
  - state = IDLE
  - heat = cool = 0
  - lt = eq = gt = 0
  - counters = 0
  - previous class = none (the first sample after reset always loads conf_cnt = 1)
- Reset mid-HEAT/COOL drops the actuator output immediately. Release is synchronous to the next rising edge.
- Latency: lt/eq/gt, state, heat and cool update on the rising edge where sample=1. They are visible in the following cycle.
- Minimum IDLE -> HEAT: CONFIRM samples. Minimum HEAT dwell: max(MIN_RUN, CONFIRM) samples.
- Back-to-back samples (sample held high) are legal; each cycle is one sample.

## Structure
- Package thermo_pkg:
  - state_t enum (IDLE, HEAT, COOL)
  - class_t enum (C_NONE, C_LT, C_EQ, C_GT)
  - state encoding constants
- Sub-module temp_classifier: combinational, parameterised by SETPOINT, temp -> class_t.
- The top level holds the FSM, both counters and the output registers.

## Test plan
Use default parameters unless stated.
1. Reset check: assert rst_n=0 with no clock running -> all outputs 0, state=0. Release rst_n, then give no samples for 10 cycles -> no output change.
2. Confirm LT: three samples of temp=5 -> heat=1 after the third sample edge. Samples 5, 5, 12 instead -> stays IDLE; the last sample gives eq=1.
3. Minimum run then reverse: enter HEAT, then feed temp=13 continuously.
   - heat stays high until the 8th sample in HEAT, then IDLE.
   - Three further samples of 13 -> cool=1.
   - heat and cool are never high together.
4. Strobe gating: hold sample=0 and toggle temp through 0..15 for 20 cycles -> state and lt/eq/gt unchanged.
5. Async reset mid-run: in COOL, pulse rst_n low between clock edges -> cool falls within the same cycle and state=IDLE. After release, two samples of temp=2 are not enough to enter HEAT; the third sample enters HEAT.
6. Chatter: alternate samples of 11 and 13 for 30 samples -> never leaves IDLE; lt/gt toggle every sample. Repeat with SETPOINT=0 and temp=0 -> eq=1, never HEAT.
